// File: rtl/aes_256_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : aes_256_ctrl
//  Purpose  : Two-requester front end for a pipelined aes_256 core. Grants
//             one block per cycle round-robin, registers the winner's operands
//             into the core, tracks every block through the core with a
//             valid/id shift register and collects results in an output FIFO.
//             Issue is credit based, so the FIFO can never overflow.
//  Ports    : clk, reset          - clock, asynchronous active-high reset
//             req0_* / req1_*     - valid/ready request ports (state + key)
//             core_state/core_key - registered operands to the aes_256 core
//             core_out            - ciphertext from the aes_256 core
//             out_valid/out_ready - result stream (first-word fall-through)
//             out_data/out_id     - head ciphertext and originating requester
//  Revision : 1.0 - initial release
// ============================================================================
module aes_256_ctrl #(
  parameter int LATENCY = 29,  // core input register to core_out valid, >= 1
  parameter int DEPTH   = 32   // output FIFO entries, power of 2, >= 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_state,
  input  logic [255:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_state,
  input  logic [255:0] req1_key,
  output logic [127:0] core_state,
  output logic [255:0] core_key,
  input  logic [127:0] core_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_id
);

  localparam int            AW      = $clog2(DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [AW-1:0] C_PINC  = AW'(1);

  logic [CW-1:0]      inflight_q, inflight_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      credit;
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic               prio_q, prio_d;
  logic               en_q;
  logic               core_vld_q, core_id_q;
  logic [LATENCY-1:0] stg_vld_q, stg_id_q;
  logic [128:0]       fifo_q [DEPTH];
  logic               has_credit, gnt0, gnt1, issue, fifo_wr, fifo_rd;

  // Credit covers both blocks still inside the core and results waiting in
  // the FIFO, so every block that leaves the core has a free FIFO slot.
  assign credit     = C_DEPTH - inflight_q - count_q;
  assign has_credit = (credit != '0);

  // en_q keeps ready low until the first clock edge after reset release.
  // A lone valid requester wins regardless of the priority pointer.
  assign gnt0  = en_q & has_credit & req0_valid & (~prio_q | ~req1_valid);
  assign gnt1  = en_q & has_credit & req1_valid & ( prio_q | ~req0_valid);
  assign issue = gnt0 | gnt1;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign fifo_wr   = stg_vld_q[LATENCY-1];
  assign out_valid = (count_q != '0);
  assign fifo_rd   = out_valid & out_ready;
  assign out_data  = fifo_q[rd_ptr_q][128:1];
  assign out_id    = fifo_q[rd_ptr_q][0];

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !fifo_wr) begin
      inflight_d = inflight_q + C_ONE;
    end else if (!issue && fifo_wr) begin
      inflight_d = inflight_q - C_ONE;
    end

    count_d = count_q;
    if (fifo_wr && !fifo_rd) begin
      count_d = count_q + C_ONE;
    end else if (!fifo_wr && fifo_rd) begin
      count_d = count_q - C_ONE;
    end

    prio_d = prio_q;
    if (gnt0) begin
      prio_d = 1'b1;
    end else if (gnt1) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      prio_q     <= 1'b0;
      en_q       <= 1'b0;
      core_vld_q <= 1'b0;
      core_id_q  <= 1'b0;
      stg_vld_q  <= '0;
      stg_id_q   <= '0;
      core_state <= '0;
      core_key   <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      prio_q     <= prio_d;
      en_q       <= 1'b1;
      if (fifo_wr) begin
        wr_ptr_q <= wr_ptr_q + C_PINC;
      end
      if (fifo_rd) begin
        rd_ptr_q <= rd_ptr_q + C_PINC;
      end
      // core_vld_q marks the operand register; the shift register follows it
      // so that its last stage lines up with core_out for that block.
      core_vld_q <= issue;
      core_id_q  <= gnt1;
      stg_vld_q  <= (stg_vld_q << 1) | LATENCY'(core_vld_q);
      stg_id_q   <= (stg_id_q  << 1) | LATENCY'(core_id_q);
      if (issue) begin
        core_state <= gnt1 ? req1_state : req0_state;
        core_key   <= gnt1 ? req1_key   : req0_key;
      end
    end
  end

  // Result storage needs no reset: only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_q[wr_ptr_q] <= {core_out, stg_id_q[LATENCY-1]};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_256_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_256_ctrl
//  Purpose  : Self-checking bench for aes_256_ctrl. Contains a behavioural
//             AES-256 core model and a transaction-level reference model of
//             the controller (outstanding-result queue, round-robin pointer).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_256_ctrl;

  localparam int LATENCY = 29;
  localparam int DEPTH   = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0] req0_state, req1_state;
  logic [255:0] req0_key, req1_key;
  logic [127:0] core_state, core_out, out_data;
  logic [255:0] core_key;
  logic         out_valid, out_ready, out_id;

  aes_256_ctrl #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_state(req0_state), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_state(req1_state), .req1_key(req1_key),
    .core_state(core_state), .core_key(core_key), .core_out(core_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- AES-256 behavioural model ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  initial begin : build_sbox
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  end

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes256(input logic [127:0] pt, input logic [255:0] key);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (i % 8 == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 14; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) s[rw+4*c] = t[rw+4*((c+rw)%4)];
      if (r < 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Core model: result for operands registered at edge E is on core_out
  // after edge E+LATENCY.
  logic [127:0] pipe [LATENCY];
  assign core_out = pipe[LATENCY-1];
  always @(posedge clk) begin
    for (int i = LATENCY-1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= aes256(core_state, core_key);
  end

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic [127:0] data;
    logic         id;
    int           t;     // negedge index at which the result becomes visible
  } exp_t;

  exp_t q[$];          // every issued block not yet popped, in issue order
  int   cyc     = 0;
  int   n_issue = 0;
  int   n_pop   = 0;

  initial begin : monitor
    bit   en, rr, ev, e0, e1, cr;
    exp_t e;
    en = 0; rr = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        q.delete();
        en = 0; rr = 0;
        chk("reset out_valid", out_valid, 0);
        chk("reset req0_ready", req0_ready, 0);
        chk("reset req1_ready", req1_ready, 0);
      end else begin
        ev = (q.size() > 0) && (q[0].t <= cyc);
        chk("out_valid", out_valid, ev);
        if (ev) begin
          chk("out_data", out_data, q[0].data);
          chk("out_id", out_id, q[0].id);
        end
        cr = en && (q.size() < DEPTH);
        e0 = cr && req0_valid && (!rr || !req1_valid);
        e1 = cr && req1_valid && ( rr || !req0_valid);
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        if (ev && out_ready) begin
          void'(q.pop_front());
          n_pop++;
        end
        if (e0 || e1) begin
          e.data = e1 ? aes256(req1_state, req1_key) : aes256(req0_state, req0_key);
          e.id   = e1;
          e.t    = cyc + LATENCY + 2;
          q.push_back(e);
          rr = e0;
          n_issue++;
        end
        en = 1;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic         id;
    logic [127:0] st;
    logic [255:0] key;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [2];

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic logic [255:0] r256();
    return {r128(), r128()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input logic id, input logic [127:0] st, input logic [255:0] k);
    bit ok = 0;
    tick();
    if (id) begin req1_valid = 1; req1_state = st; req1_key = k; end
    else    begin req0_valid = 1; req0_state = st; req0_key = k; end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) ok = 1;
    end
    chk("issue handshake", ok, 1);
    tick();
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic wait_out(output int lat);
    bit seen = 0;
    lat = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      lat++;
      if (out_valid) seen = 1;
    end
    chk("out_valid timeout", seen, 1);
  endtask

  task automatic drain();
    bit done = 0;
    req0_valid = 0;
    req1_valid = 0;
    out_ready  = 1;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (q.size() == 0 && !out_valid) done = 1;
    end
    chk("drain timeout", done, 1);
  endtask

  initial begin : main
    int lat, n0, p0, seen;
    vecs[0] = '{1'b0, 128'h00112233445566778899aabbccddeeff,
                256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h8ea2b7ca516745bfeafc49904b496089};
    vecs[1] = '{1'b1, 128'h3243f6a8885a308d313198a2e0370734,
                256'h2b7e151628aed2a6abf7158809cf4f3c762e7160f38b4da56a784d9045190cfe,
                128'h1a6e6c2c662e7da6501ffb62bc9e93f3};
    reset = 1; out_ready = 1;
    req0_valid = 0; req1_valid = 0;
    req0_state = '0; req1_state = '0; req0_key = '0; req1_key = '0;
    repeat (3) tick();
    chk("reset core_state", core_state, 0);
    chk("reset core_key", core_key, 0);
    reset = 0;

    // Known-answer vectors, one at a time, with latency measurement.
    for (int v = 0; v < 2; v++) begin
      issue_one(vecs[v].id, vecs[v].st, vecs[v].key);
      wait_out(lat);
      chk("kat latency", lat, LATENCY + 1);
      chk("kat out_data", out_data, vecs[v].ct);
      chk("kat out_id", out_id, vecs[v].id);
      repeat (2) tick();
    end

    // Requester 1 then requester 0 on the next cycle: consecutive results.
    tick();
    req1_valid = 1; req1_state = vecs[1].st; req1_key = vecs[1].key;
    tick();
    req1_valid = 0;
    req0_valid = 1; req0_state = vecs[0].st; req0_key = vecs[0].key;
    tick();
    req0_valid = 0;
    wait_out(lat);
    chk("pair first data", out_data, vecs[1].ct);
    chk("pair first id", out_id, 1);
    tick();
    chk("pair second valid", out_valid, 1);
    chk("pair second data", out_data, vecs[0].ct);
    chk("pair second id", out_id, 0);
    drain();

    // Both requesters streaming, output always ready.
    n0 = n_issue; p0 = n_pop;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 64; i++) begin
      req0_state = r128(); req0_key = r256();
      req1_state = r128(); req1_key = r256();
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    chk("stream issues", n_issue - n0, 64);
    drain();
    chk("stream results", n_pop - p0, 64);

    // Credit exhaustion with a stalled output, then a single pop.
    n0 = n_issue;
    out_ready = 0;
    req0_valid = 1; req0_state = r128(); req0_key = r256();
    repeat (80) tick();
    chk("full issues", n_issue - n0, DEPTH);
    chk("full req0_ready", req0_ready, 0);
    n0 = n_issue;
    out_ready = 1;
    tick();
    out_ready = 0;
    req0_state = r128();
    chk("ready after pop", req0_ready, 1);
    repeat (10) tick();
    chk("issues after pop", n_issue - n0, 1);
    drain();

    // Reset with 10 blocks in flight and 5 results in the FIFO.
    out_ready = 0;
    req0_valid = 1;
    for (int i = 0; i < 15; i++) begin
      req0_state = r128(); req0_key = r256();
      tick();
    end
    req0_valid = 0;
    wait_out(lat);
    repeat (4) tick();
    chk("pre-reset out_valid", out_valid, 1);
    reset = 1;
    req0_valid = 1;
    #1;
    chk("async reset out_valid", out_valid, 0);
    chk("async reset req0_ready", req0_ready, 0);
    repeat (2) tick();
    reset = 0;
    #1;
    chk("ready before first edge", req0_ready, 0);
    tick();
    req0_valid = 0;
    out_ready = 1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("stale results after reset", seen, 0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      req0_valid = ($urandom_range(0, 1) == 1);
      req1_valid = ($urandom_range(0, 1) == 1);
      out_ready  = ($urandom_range(0, 9) < 7);
      req0_state = r128(); req0_key = r256();
      req1_state = r128(); req1_key = r256();
      tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_256_ctrl.md
AES_256_CTRL -- requirements
Module: aes_256_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 29: aes_256 core latency in clk cycles, from core input registered to core_out valid.
REQ-002 SHALL have parameter DEPTH, default 32: output FIFO entries; power of 2, >= 2.
REQ-003 SHALL have clk  in  1: single clock; all state on rising edge.
REQ-004 SHALL have reset  in  1: asynchronous, active-high reset.
REQ-005 SHALL have req0_valid  in  1, req0_ready  out  1, req0_state  in  128, req0_key  in  256: requester 0 block and key.
REQ-006 SHALL have req1_valid  in  1, req1_ready  out  1, req1_state  in  128, req1_key  in  256: requester 1 block and key.
REQ-007 SHALL have core_state  out  128, core_key  out  256: registered operands to the aes_256 instance.
REQ-008 SHALL have core_out  in  128: ciphertext from the aes_256 instance.
REQ-009 SHALL have out_valid  out  1, out_ready  in  1, out_data  out  128, out_id  out  1: result stream; out_id is the originating requester.

Function
REQ-010 SHALL accept a request on a rising edge where reqN_valid and reqN_ready are both high (issue); at most one issue per cycle.
REQ-011 SHALL arbitrate round-robin: priority pointer reset to 0; after an issue from requester i the pointer becomes 1-i; with no issue the pointer holds.
REQ-012 SHALL drive reqN_ready high only when credit > 0 and requester N wins arbitration; a requester alone with valid wins regardless of pointer.
REQ-013 SHALL compute reqN_ready from registered state and the req valids only, never combinationally from out_ready.
REQ-014 SHALL define credit = DEPTH - inflight - fifo_count, all counters log2(DEPTH)+1 bits, never negative.
REQ-015 SHALL on issue register the winner's state/key into core_state/core_key; with no issue, core_state/core_key hold their previous values.
REQ-016 SHALL track each issue with a LATENCY-stage valid+id shift register aligned to the core pipeline; stage LATENCY-1 output qualifies core_out.
REQ-017 SHALL write {core_out, id} into the FIFO when the final shift stage is valid; the write is never dropped (guaranteed by credit).
REQ-018 SHALL make out_valid = fifo_count != 0, first-word fall-through; out_data/out_id show the head entry; pop on out_valid & out_ready.
REQ-019 SHALL increment inflight on issue and decrement it on FIFO write; both in one cycle leave it unchanged.
REQ-020 SHALL handle simultaneous FIFO write and pop: count unchanged, pointers both advance, wrap modulo DEPTH.
REQ-021 SHALL give issue-to-out_valid latency exactly LATENCY+1 cycles when the FIFO is empty.
REQ-022 SHALL sustain one issue per cycle indefinitely when out_ready is held high and DEPTH >= LATENCY+2.
REQ-023 SHALL stop issuing when credit reaches 0, i.e. when the FIFO is full or will be filled by in-flight blocks; the credit freed by a pop is visible the next cycle.
REQ-024 SHALL preserve issue order on the output; results of the two requesters interleave in grant order.

Reset
REQ-025 SHALL on reset assertion immediately clear the shift-register valids, inflight, fifo_count, FIFO pointers and priority pointer, force out_valid/req0_ready/req1_ready low, and zero core_state/core_key.
REQ-026 SHALL discard in-flight blocks and FIFO contents on reset mid-operation; aes_256 pipeline garbage is never written after reset.
REQ-027 SHALL drive reqN_ready no earlier than the first rising edge after reset deassertion.

Verification
REQ-028 SHALL pass: req0 issues state 00112233445566778899aabbccddeeff, key 000102..1e1f -> out_data 8ea2b7ca516745bfeafc49904b496089, out_id 0, out_valid exactly 30 cycles after issue.
REQ-029 SHALL pass: req1 state 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c762e7160f38b4da56a784d9045190cfe, then req0 vector of REQ-028 on the next cycle -> 1a6e6c2c662e7da6501ffb62bc9e93f3 (id 1) then 8ea2b7ca... (id 0) on consecutive cycles.
REQ-030 SHALL pass: both requesters valid continuously, out_ready high -> grants alternate 0,1,0,1...; 64 results in order, one per cycle after the first.
REQ-031 SHALL pass: out_ready low, req0 valid continuously -> exactly 32 issues, then req0_ready low; out_ready high for one pop -> exactly one more issue the cycle after the pop; no result lost.
REQ-032 SHALL pass: reset asserted with 10 blocks in flight and 5 in the FIFO -> out_valid low immediately; after deassertion no stale result appears within 40 cycles.
